systolic_pe: RTL and testbench



---
 rtl/systolic_pe_if.sv | 28 ++
 rtl/systolic_pe.sv | 65 ++++++
 tb/tb_systolic_pe.sv | 136 +++++++++++++
 3 files changed

// File: rtl/systolic_pe_if.sv
// Port bundle between one systolic PE and the array fabric around it.
// The array controller (master) drives mode, partial sum and activation; the PE (slave) returns the registered outputs.
interface systolic_pe_if #(
  parameter int ADD_BW = 32,
  parameter int MUL_BW = 16
);
  logic              i_mode;
  logic [ADD_BW-1:0] i_top;
  logic [MUL_BW-1:0] i_left;
  logic [ADD_BW-1:0] o_bot;
  logic [MUL_BW-1:0] o_right;

  modport master (
    output i_mode,
    output i_top,
    output i_left,
    input  o_bot,
    input  o_right
  );

  modport slave (
    input  i_mode,
    input  i_top,
    input  i_left,
    output o_bot,
    output o_right
  );
endinterface

// File: rtl/systolic_pe.sv
// Weight-stationary systolic array processing element: loads a weight from the top, then
// multiply-accumulates left activations into top partial sums with one cycle of latency.
module systolic_pe #(
  parameter int ADD_BW = 32,
  parameter int MUL_BW = 16
) (
  input  logic         clk,
  input  logic         rst,
  systolic_pe_if.slave pe
);

  localparam int PROD_BW = 2 * MUL_BW;

  // The full product must fit the partial-sum path without truncation.
  if (ADD_BW < PROD_BW) begin : g_width_check
    $error("systolic_pe: ADD_BW must be >= 2*MUL_BW");
  end

  // Unsigned multiply-accumulate that wraps modulo 2^ADD_BW.
  function automatic logic [ADD_BW-1:0] mac_wrap(
    input logic [ADD_BW-1:0] psum,
    input logic [MUL_BW-1:0] w,
    input logic [MUL_BW-1:0] a
  );
    logic [PROD_BW-1:0] prod;
    prod = PROD_BW'(w) * PROD_BW'(a);
    return psum + ADD_BW'(prod);
  endfunction

  function automatic logic [ADD_BW-1:0] zext_weight(input logic [ADD_BW-1:0] top);
    return ADD_BW'(top[MUL_BW-1:0]);
  endfunction

  logic [MUL_BW-1:0] weight_q;
  logic [MUL_BW-1:0] weight_nxt;
  logic [ADD_BW-1:0] bot_nxt;
  logic [ADD_BW-1:0] bot_p1;
  logic [MUL_BW-1:0] right_p1;

  always_comb begin
    weight_nxt = weight_q;
    bot_nxt    = mac_wrap(pe.i_top, weight_q, pe.i_left);
    if (!pe.i_mode) begin
      weight_nxt = pe.i_top[MUL_BW-1:0];
      bot_nxt    = zext_weight(pe.i_top);
    end
  end

  // Stage p0 -> p1: single register boundary, so array skew is one cycle per PE.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q <= '0;
      bot_p1   <= '0;
      right_p1 <= '0;
    end else begin
      weight_q <= weight_nxt;
      bot_p1   <= bot_nxt;
      right_p1 <= pe.i_left;
    end
  end

  assign pe.o_bot   = bot_p1;
  assign pe.o_right = right_p1;

endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe: directed scenarios plus randomized stress
// compared against an arithmetic reference model.
module tb_systolic_pe;

  localparam int ADD_BW = 32;
  localparam int MUL_BW = 16;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [MUL_BW-1:0] m_w;
  logic [ADD_BW-1:0] m_bot;
  logic [MUL_BW-1:0] m_right;

  systolic_pe_if #(.ADD_BW(ADD_BW), .MUL_BW(MUL_BW)) pe_bus ();

  systolic_pe #(.ADD_BW(ADD_BW), .MUL_BW(MUL_BW)) dut (
    .clk (clk),
    .rst (rst),
    .pe  (pe_bus)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, update the model, sample #1 after the edge.
  task automatic step(input logic r, input logic mode, input logic [31:0] top, input logic [15:0] left);
    logic [63:0] sum;
    @(negedge clk);
    rst           = r;
    pe_bus.i_mode = mode;
    pe_bus.i_top  = top;
    pe_bus.i_left = left;
    if (r) begin
      m_w = '0; m_bot = '0; m_right = '0;
    end else if (!mode) begin
      m_w     = top[15:0];
      m_bot   = {16'h0, top[15:0]};
      m_right = left;
    end else begin
      sum     = 64'(top) + 64'(m_w) * 64'(left);
      m_bot   = sum[31:0];
      m_right = left;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 32'hDEADBEEF, 16'hFFFF);
    total++; if (pe_bus.o_bot !== 32'h0) begin bad++; $display("FAIL reset_bot got=%h want=%h", pe_bus.o_bot, 32'h0); end
    total++; if (pe_bus.o_right !== 16'h0) begin bad++; $display("FAIL reset_right got=%h want=%h", pe_bus.o_right, 16'h0); end
    step(1'b0, 1'b1, 32'h5, 16'h7);
    total++; if (pe_bus.o_bot !== 32'h5) begin bad++; $display("FAIL reset_weight_zero got=%h want=%h", pe_bus.o_bot, 32'h5); end
  endtask

  task automatic test_load();
    step(1'b0, 1'b0, 32'hABCD1234, 16'h5678);
    total++; if (pe_bus.o_bot !== 32'h00001234) begin bad++; $display("FAIL load_bot got=%h want=%h", pe_bus.o_bot, 32'h00001234); end
    total++; if (pe_bus.o_right !== 16'h5678) begin bad++; $display("FAIL load_right got=%h want=%h", pe_bus.o_right, 16'h5678); end
  endtask

  task automatic test_compute();
    step(1'b0, 1'b1, 32'h11111111, 16'h0002);
    total++; if (pe_bus.o_bot !== 32'h11113579) begin bad++; $display("FAIL compute_bot got=%h want=%h", pe_bus.o_bot, 32'h11113579); end
    total++; if (pe_bus.o_right !== 16'h0002) begin bad++; $display("FAIL compute_right got=%h want=%h", pe_bus.o_right, 16'h0002); end
    step(1'b0, 1'b1, 32'h0, 16'h0010);
    total++; if (pe_bus.o_bot !== 32'h00012340) begin bad++; $display("FAIL weight_hold got=%h want=%h", pe_bus.o_bot, 32'h00012340); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 32'h0000FFFF, 16'h0);
    total++; if (pe_bus.o_bot !== 32'h0000FFFF) begin bad++; $display("FAIL wrap_load got=%h want=%h", pe_bus.o_bot, 32'h0000FFFF); end
    step(1'b0, 1'b1, 32'hFFFFFFFF, 16'hFFFF);
    total++; if (pe_bus.o_bot !== 32'hFFFE0000) begin bad++; $display("FAIL wrap_bot got=%h want=%h", pe_bus.o_bot, 32'hFFFE0000); end
  endtask

  task automatic test_reset_priority();
    step(1'b0, 1'b0, 32'h00000003, 16'h1);
    step(1'b0, 1'b1, 32'h10, 16'h4);
    total++; if (pe_bus.o_bot !== 32'h1C) begin bad++; $display("FAIL prio_pre got=%h want=%h", pe_bus.o_bot, 32'h1C); end
    step(1'b1, 1'b1, 32'h10, 16'h4);
    total++; if (pe_bus.o_bot !== 32'h0) begin bad++; $display("FAIL prio_rst_bot got=%h want=%h", pe_bus.o_bot, 32'h0); end
    total++; if (pe_bus.o_right !== 16'h0) begin bad++; $display("FAIL prio_rst_right got=%h want=%h", pe_bus.o_right, 16'h0); end
    step(1'b0, 1'b1, 32'h10, 16'h4);
    total++; if (pe_bus.o_bot !== 32'h10) begin bad++; $display("FAIL prio_cleared got=%h want=%h", pe_bus.o_bot, 32'h10); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] t;
    logic [15:0] l;
    for (int i = 0; i < 16; i++) begin
      t = $urandom;
      l = 16'($urandom);
      step(1'b0, 1'(i % 2), t, l);
      total++; if (pe_bus.o_bot !== m_bot) begin bad++; $display("FAIL b2b_bot[%0d] got=%h want=%h", i, pe_bus.o_bot, m_bot); end
    end
  endtask

  task automatic test_random();
    logic        r;
    logic        mode;
    logic [31:0] t;
    logic [15:0] l;
    for (int i = 0; i < 1000; i++) begin
      r    = ($urandom_range(0, 31) == 0);
      mode = ($urandom_range(0, 3) != 0);
      t    = $urandom;
      l    = 16'($urandom);
      step(r, mode, t, l);
      total++; if (pe_bus.o_bot !== m_bot) begin bad++; $display("FAIL rand_bot[%0d] got=%h want=%h", i, pe_bus.o_bot, m_bot); end
      total++; if (pe_bus.o_right !== m_right) begin bad++; $display("FAIL rand_right[%0d] got=%h want=%h", i, pe_bus.o_right, m_right); end
    end
  endtask

  initial begin
    rst = 1'b1;
    pe_bus.i_mode = 1'b0;
    pe_bus.i_top  = '0;
    pe_bus.i_left = '0;
    m_w = '0; m_bot = '0; m_right = '0;
    test_reset();
    test_load();
    test_compute();
    test_wrap();
    test_reset_priority();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
